// File: rtl/loader_pkg.sv
// Shared types and constants for the memory stream loader (FSM states, frame field sizes).
package loader_pkg;

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_CNT,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam logic [3:0] MEM_EN_ALL = 4'hF;

endpackage

// File: rtl/mem_stream_loader_byte_word_packer.sv
// Little-endian 4-byte assembler: presents the completed word combinationally with the
// strobe on the byte that finishes it, so header fields and data words share one path.
module byte_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        last,
  output logic        at_first
);

  logic [1:0]  idx_p0;
  logic [23:0] sh_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p0 <= '0;
    end else if (in_vld) begin
      idx_p0 <= idx_p0 + 2'd1;
    end
  end

  // byte lanes: earlier bytes shift down so the newest lands in the top lane
  always_ff @(posedge clk) begin
    if (in_vld) begin
      sh_p0 <= {in_byte, sh_p0[23:8]};
    end
  end

  assign word     = {in_byte, sh_p0};
  assign last     = in_vld && (idx_p0 == 2'(WORD_BYTES - 1));
  assign at_first = (idx_p0 == 2'd0);

endmodule

// File: rtl/mem_stream_loader.sv
// Framed byte-stream loader writing 32-bit words to the data memory B port.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module mem_stream_loader
  import loader_pkg::*;
#(
  parameter int AW = 14,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_we,
  output logic [3:0]    mem_en,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] words_written
);

  state_t        state;
  logic [AW-1:0] base;
  logic [CW-1:0] count;
  logic          acc;
  logic          pk_vld;
  logic [31:0]   pk_word;
  logic          pk_last;
  logic          pk_first;
  logic          body_end;

  assign rx_ready = (state != ST_DONE);
  assign acc      = rx_valid && rx_ready;
  assign pk_vld   = acc && (state != ST_CSUM);

  byte_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (pk_vld),
    .in_byte  (rx_data),
    .word     (pk_word),
    .last     (pk_last),
    .at_first (pk_first)
  );

  // Last header byte of an empty frame, or last byte of the last data word
  assign body_end = (state == ST_CNT  && pk_last && pk_word[CW-1:0] == '0) ||
                    (state == ST_DATA && pk_last && (words_written + CW'(1)) == count);

  always_ff @(posedge clk) begin
    if (state == ST_ADDR && pk_last) base  <= pk_word[AW-1:0];
    if (state == ST_CNT  && pk_last) count <= pk_word[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ADDR;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_we        <= 1'b0;
      mem_en        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_en <= '0;
      done   <= 1'b0;
      unique case (state)
        ST_ADDR: begin
          if (acc && pk_first) begin
            busy          <= 1'b1;
            words_written <= '0;
          end
          if (pk_last) state <= ST_CNT;
        end
        ST_CNT: begin
          if (pk_last && !body_end) state <= ST_DATA;
        end
        ST_DATA: begin
          if (pk_last) begin
            mem_addr      <= base + AW'(words_written);
            mem_din       <= pk_word;
            mem_we        <= 1'b1;
            mem_en        <= MEM_EN_ALL;
            words_written <= words_written + CW'(1);
          end
        end
        ST_CSUM: begin
          if (acc) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_ADDR;
        default: state <= ST_ADDR;
      endcase
      if (body_end) begin
`ifdef LOADER_CHECKSUM_EN
        state <= ST_CSUM;
`else
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
`endif
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ST_ADDR && acc && pk_first) begin
        csum  <= '0;
        err_q <= 1'b0;
      end
      if (state == ST_DATA && acc) csum <= csum ^ rx_data;
      if (state == ST_CSUM && acc) err_q <= (rx_data != csum);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stream_loader.sv
// Self-checking bench for mem_stream_loader: table of frames, random frames, mid-frame reset.
module tb_mem_stream_loader;

  localparam int AW = 14;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          mem_we;
  logic [3:0]    mem_en;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] words_written;

  mem_stream_loader #(.AW(AW), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_we        (mem_we),
    .mem_en        (mem_en),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int bad_ready   = 0;
  int bad_en      = 0;
  int last_acc    = 0;
  logic prev_err  = 1'b0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_din[$];
  int          wq_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write observer: logs every write with the cycle it was visible in
  always @(negedge clk) begin
    if (!rst) begin
      if (!rx_ready && !done) bad_ready++;
      if (mem_en !== (mem_we ? 4'hF : 4'h0)) bad_en++;
      if (mem_we) begin
        wq_addr.push_back(32'(mem_addr));
        wq_din.push_back(mem_din);
        wq_cyc.push_back(cyc);
      end
    end
  end

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bit ok;
    while ($urandom_range(99) < gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 40) begin
      @(negedge clk);
      if (rx_ready) begin
        last_acc = cyc;
        ok = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    rx_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_frame(input logic [31:0] base, input logic [31:0] cnt_raw, input int gap,
                           input bit bad, input bit rnd,
                           output logic [31:0] a0, output logic [31:0] d0);
    int          cnt;
    int          wbase;
    logic [7:0]  d[$];
    int          acyc[$];
    logic [7:0]  x;
    logic        exp_err;
    cnt   = int'(cnt_raw[15:0]);
    wbase = wq_addr.size();
    x     = 8'h00;
    a0    = '0;
    d0    = '0;
    for (int i = 0; i < cnt * 4; i++) d.push_back(rnd ? 8'($urandom) : 8'((i + 1) * 17));
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("err_held_idle", 32'(err), 32'(prev_err));
    send_byte(base[7:0], gap);
    chk("busy_after_first", 32'(busy), 32'd1);
    chk("err_clear_first", 32'(err), 32'd0);
    for (int i = 1; i < 4; i++) send_byte(base[8*i +: 8], gap);
    for (int i = 0; i < 4; i++) send_byte(cnt_raw[8*i +: 8], gap);
    for (int i = 0; i < cnt * 4; i++) begin
      send_byte(d[i], gap);
      acyc.push_back(last_acc);
      x = x ^ d[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad ? (x ^ 8'h01) : x, gap);
    exp_err = bad;
`else
    exp_err = 1'b0;
`endif
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_low_done", 32'(rx_ready), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("words_written", 32'(words_written), 32'(cnt));
    chk("err_result", 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after_done", 32'(rx_ready), 32'd1);
    chk("write_count", 32'(wq_addr.size() - wbase), 32'(cnt));
    for (int w = 0; w < cnt && (wbase + w) < wq_addr.size(); w++) begin
      chk("wr_addr", wq_addr[wbase + w], (base + 32'(w)) & 32'h3FFF);
      chk("wr_data", wq_din[wbase + w], {d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]});
      chk("wr_latency", 32'(wq_cyc[wbase + w]), 32'(acyc[4*w+3] + 1));
    end
    if (wq_addr.size() > wbase) begin
      a0 = wq_addr[wbase];
      d0 = wq_din[wbase];
    end
    chk("ready_only_in_done", 32'(bad_ready), 32'd0);
    chk("mem_en_matches_we", 32'(bad_en), 32'd0);
    prev_err = exp_err;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] cnt_raw;
    int          gap;
    bit          bad;
    logic [31:0] exp_addr0;
    logic [31:0] exp_din0;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] a0, d0;
    int          wbase;

    tbl[0] = '{32'h0000_0010, 32'h0000_0002, 0,  1'b0, 32'h0010, 32'h4433_2211};
    tbl[1] = '{32'hABCD_0123, 32'h0000_0000, 0,  1'b1, 32'h0000, 32'h0000_0000};
    tbl[2] = '{32'h0000_3FFF, 32'h0000_0002, 0,  1'b0, 32'h3FFF, 32'h4433_2211};
    tbl[3] = '{32'h0000_0010, 32'hDEAD_0002, 50, 1'b0, 32'h0010, 32'h4433_2211};
    tbl[4] = '{32'h0000_0010, 32'h0000_0002, 0,  1'b1, 32'h0010, 32'h4433_2211};
    tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0003, 30, 1'b0, 32'h3FFF, 32'h4433_2211};
    tbl[6] = '{32'h5555_1234, 32'h0000_0001, 0,  1'b0, 32'h1234, 32'h4433_2211};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].base, tbl[i].cnt_raw, tbl[i].gap, tbl[i].bad, 1'b0, a0, d0);
      if (tbl[i].cnt_raw[15:0] != 16'd0) begin
        chk("tbl_first_addr", a0, tbl[i].exp_addr0);
        chk("tbl_first_data", d0, tbl[i].exp_din0);
      end
    end

    for (int i = 0; i < 8; i++) begin
      run_frame($urandom, {16'($urandom), 16'($urandom_range(0, 5))},
                $urandom_range(0, 60), 1'($urandom_range(0, 1)), 1'b1, a0, d0);
    end

    // Mid-frame reset after six data bytes: one word lands, the half word is dropped
    wbase = wq_addr.size();
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 0);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    @(posedge clk); #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_en", 32'(mem_en), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_din", mem_din, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_words", 32'(words_written), 32'd0);
    chk("mid_rst_ready", 32'(rx_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_write_count", 32'(wq_addr.size() - wbase), 32'd1);
    if (wq_addr.size() > wbase) begin
      chk("mid_rst_wr_addr", wq_addr[wbase], 32'h0000_0100);
      chk("mid_rst_wr_data", wq_din[wbase], 32'hA3A2_A1A0);
    end
    prev_err = 1'b0;
    run_frame(32'h0000_0200, 32'h0000_0002, 20, 1'b0, 1'b0, a0, d0);
    chk("post_rst_first_addr", a0, 32'h0000_0200);
    chk("post_rst_first_data", d0, 32'h4433_2211);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
